sprdma_gen: RTL and testbench

//  Parametrised successor of the sprite DMA engine. Snoops CPU writes to a trigger register.
//  It then copies 2**LEN_LOG2 bytes from a CPU page to a fixed destination register over the cpumc bus.

---
 rtl/sprdma_gen_if.sv | 27 ++
 rtl/sprdma_gen.sv | 150 +++++++++++++++
 tb/tb_sprdma_gen.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprdma_gen_if.sv
// Signal bundle between the sprite DMA engine and the CPU/memory side.
// The DMA engine drives the bus outputs, so it takes the master modport.
interface sprdma_gen_if #(
   parameter int unsigned LEN_LOG2 = 8
) ();
   logic [15:0]       cpumc_a_in;
   logic [7:0]        cpumc_din_in;
   logic [7:0]        cpumc_dout_in;
   logic              cpu_r_nw_in;
   logic              pause_in;
   logic              active_out;
   logic [15:0]       cpumc_a_out;
   logic [7:0]        cpumc_d_out;
   logic              cpumc_r_nw_out;
   logic              done_out;
   logic [LEN_LOG2:0] cnt_out;

   modport master (
      input  cpumc_a_in, cpumc_din_in, cpumc_dout_in, cpu_r_nw_in, pause_in,
      output active_out, cpumc_a_out, cpumc_d_out, cpumc_r_nw_out, done_out, cnt_out
   );

   modport slave (
      output cpumc_a_in, cpumc_din_in, cpumc_dout_in, cpu_r_nw_in, pause_in,
      input  active_out, cpumc_a_out, cpumc_d_out, cpumc_r_nw_out, done_out, cnt_out
   );
endinterface

// File: rtl/sprdma_gen.sv
// Sprite DMA engine: a CPU write to TRIG_ADDR copies 2**LEN_LOG2 bytes from the
// written page to DST_ADDR, one read/write pair per byte, with optional pause.
module sprdma_gen #(
   parameter logic [15:0] TRIG_ADDR    = 16'h4014,
   parameter logic [15:0] DST_ADDR     = 16'h2004,
   parameter int unsigned LEN_LOG2     = 8,
   parameter int unsigned READ_LAT     = 1,
   parameter int unsigned ALIGN_CYCLES = 1
) (
   input logic          clk_in,
   input logic          rst_in,
   sprdma_gen_if.master bus
);

   localparam int unsigned OFF_W = LEN_LOG2;
   localparam int unsigned CNT_W = LEN_LOG2 + 1;
   localparam logic [OFF_W-1:0] OFF_LAST   = '1;
   localparam logic [1:0]       READ_LAST  = 2'(READ_LAT);
   localparam logic [1:0]       ALIGN_LAST = (ALIGN_CYCLES == 0) ? 2'd0 : 2'(ALIGN_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_READ,
      ST_WRITE,
      ST_PAUSE,
      ST_COOLDOWN
   } state_e;

   state_e           state_q;
   logic [7:0]       page_q;
   logic [OFF_W-1:0] offset_q;
   logic [OFF_W-1:0] offset_d;
   logic [1:0]       sub_q;
   logic [CNT_W-1:0] cnt_q;
   logic [15:0]      a_q;
   logic [7:0]       d_q;
   logic             r_nw_q;
   logic             done_q;
   logic             active_q;
   logic             trigger_c;
   logic             last_c;

   function automatic logic [15:0] src_addr(input logic [7:0] page, input logic [OFF_W-1:0] off);
      return {page, 8'h00} + 16'(off);
   endfunction

   assign trigger_c = (bus.cpumc_a_in == TRIG_ADDR) && !bus.cpu_r_nw_in;
   assign last_c    = (offset_q == OFF_LAST);
   assign offset_d  = offset_q + OFF_W'(1);

   // Bus outputs default to idle each cycle; only the branch entering or staying in READ/WRITE drives them.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= ST_IDLE;
         page_q   <= '0;
         offset_q <= '0;
         sub_q    <= '0;
         cnt_q    <= '0;
         a_q      <= '0;
         d_q      <= '0;
         r_nw_q   <= 1'b1;
         done_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         a_q    <= '0;
         d_q    <= '0;
         r_nw_q <= 1'b1;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (trigger_c) begin
                  page_q   <= bus.cpumc_din_in;
                  offset_q <= '0;
                  cnt_q    <= '0;
                  sub_q    <= '0;
                  active_q <= 1'b1;
                  if (ALIGN_CYCLES != 0) begin
                     state_q <= ST_ALIGN;
                  end else begin
                     state_q <= ST_READ;
                     a_q     <= src_addr(bus.cpumc_din_in, '0);
                  end
               end
            end
            ST_ALIGN: begin
               if (sub_q == ALIGN_LAST) begin
                  sub_q   <= '0;
                  state_q <= ST_READ;
                  a_q     <= src_addr(page_q, offset_q);
               end else begin
                  sub_q <= sub_q + 2'd1;
               end
            end
            ST_READ: begin
               if (sub_q == READ_LAST) begin
                  sub_q   <= '0;
                  state_q <= ST_WRITE;
                  a_q     <= DST_ADDR;
                  d_q     <= bus.cpumc_dout_in;
                  r_nw_q  <= 1'b0;
                  done_q  <= last_c;
               end else begin
                  sub_q <= sub_q + 2'd1;
                  a_q   <= src_addr(page_q, offset_q);
               end
            end
            ST_WRITE: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_c) begin
                  state_q  <= ST_COOLDOWN;
                  active_q <= 1'b0;
               end else begin
                  offset_q <= offset_d;
                  if (bus.pause_in) begin
                     state_q <= ST_PAUSE;
                  end else begin
                     state_q <= ST_READ;
                     a_q     <= src_addr(page_q, offset_d);
                  end
               end
            end
            ST_PAUSE: begin
               if (!bus.pause_in) begin
                  state_q <= ST_READ;
                  a_q     <= src_addr(page_q, offset_q);
               end
            end
            ST_COOLDOWN: begin
               // Wait for the CPU to release its write so a held trigger cannot restart us.
               if (bus.cpu_r_nw_in) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.active_out     = active_q;
   assign bus.cpumc_a_out    = a_q;
   assign bus.cpumc_d_out    = d_q;
   assign bus.cpumc_r_nw_out = r_nw_q;
   assign bus.done_out       = done_q;
   assign bus.cnt_out        = cnt_q;

endmodule

// File: tb/tb_sprdma_gen.sv
// Scoreboard bench for sprdma_gen: three configurations, a latency-aware memory
// model per instance, and expected read/write pairs queued at each trigger.
module tb_sprdma_gen;

   localparam logic [15:0] TRIG = 16'h4014;
   localparam logic [15:0] DST  = 16'h2004;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        last;
   } exp_t;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   sprdma_gen_if #(.LEN_LOG2(8))  b0 ();
   sprdma_gen_if #(.LEN_LOG2(2))  b1 ();
   sprdma_gen_if #(.LEN_LOG2(12)) b2 ();

   sprdma_gen #(.TRIG_ADDR(TRIG), .DST_ADDR(DST), .LEN_LOG2(8), .READ_LAT(1), .ALIGN_CYCLES(1))
      u0 (.clk_in(clk), .rst_in(rst), .bus(b0));
   sprdma_gen #(.TRIG_ADDR(TRIG), .DST_ADDR(DST), .LEN_LOG2(2), .READ_LAT(2), .ALIGN_CYCLES(0))
      u1 (.clk_in(clk), .rst_in(rst), .bus(b1));
   sprdma_gen #(.TRIG_ADDR(TRIG), .DST_ADDR(DST), .LEN_LOG2(12), .READ_LAT(2), .ALIGN_CYCLES(0))
      u2 (.clk_in(clk), .rst_in(rst), .bus(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [7:0] mem(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Memory returns valid data only once the read address has been stable READ_LAT cycles.
   logic [15:0] la0 = '0, la1 = '0, la2 = '0;
   logic        lr0 = 1'b0, lr1 = 1'b0, lr2 = 1'b0;
   int          run0 = 0, run1 = 0, run2 = 0;
   wire rd0 = b0.active_out & b0.cpumc_r_nw_out;
   wire rd1 = b1.active_out & b1.cpumc_r_nw_out;
   wire rd2 = b2.active_out & b2.cpumc_r_nw_out;

   always @(posedge clk) begin
      run0 <= (rd0 && lr0 && b0.cpumc_a_out == la0) ? run0 + 1 : (rd0 ? 1 : 0);
      run1 <= (rd1 && lr1 && b1.cpumc_a_out == la1) ? run1 + 1 : (rd1 ? 1 : 0);
      run2 <= (rd2 && lr2 && b2.cpumc_a_out == la2) ? run2 + 1 : (rd2 ? 1 : 0);
      la0 <= b0.cpumc_a_out; lr0 <= rd0;
      la1 <= b1.cpumc_a_out; lr1 <= rd1;
      la2 <= b2.cpumc_a_out; lr2 <= rd2;
   end

   assign b0.cpumc_dout_in = (rd0 && (((lr0 && b0.cpumc_a_out == la0) ? run0 : 0) >= 1))
                             ? mem(b0.cpumc_a_out) : 8'hEE;
   assign b1.cpumc_dout_in = (rd1 && (((lr1 && b1.cpumc_a_out == la1) ? run1 : 0) >= 2))
                             ? mem(b1.cpumc_a_out) : 8'hEE;
   assign b2.cpumc_dout_in = (rd2 && (((lr2 && b2.cpumc_a_out == la2) ? run2 : 0) >= 2))
                             ? mem(b2.cpumc_a_out) : 8'hEE;

   // Output monitors: idle bus when inactive, and one scoreboard pop per write.
   int act0 = 0, act1 = 0, act2 = 0;
   int done0 = 0, done1 = 0, done2 = 0;
   int wr0 = 0;
   logic [15:0] pa0 = '0, pa1 = '0, pa2 = '0;
   exp_t e0, e1, e2;

   always @(negedge clk) begin
      if (b0.active_out) act0++;
      if (b0.done_out) done0++;
      if (!b0.active_out) begin
         check_eq("u0_idle_bus", 32'({b0.cpumc_a_out, b0.cpumc_d_out, b0.cpumc_r_nw_out, b0.done_out}),
                  32'({16'h0000, 8'h00, 1'b1, 1'b0}));
      end else if (!b0.cpumc_r_nw_out) begin
         wr0++;
         if (q0.size() == 0) check_eq("u0_extra_write", 32'(b0.cpumc_a_out), 32'hFFFF_FFFF);
         else begin
            e0 = q0.pop_front();
            check_eq("u0_src_addr", 32'(pa0), 32'(e0.addr));
            check_eq("u0_dst_addr", 32'(b0.cpumc_a_out), 32'(DST));
            check_eq("u0_data", 32'(b0.cpumc_d_out), 32'(e0.data));
            check_eq("u0_done", 32'(b0.done_out), 32'(e0.last));
         end
      end
      pa0 = b0.cpumc_a_out;
   end

   always @(negedge clk) begin
      if (b1.active_out) act1++;
      if (b1.done_out) done1++;
      if (!b1.active_out) begin
         check_eq("u1_idle_bus", 32'({b1.cpumc_a_out, b1.cpumc_d_out, b1.cpumc_r_nw_out, b1.done_out}),
                  32'({16'h0000, 8'h00, 1'b1, 1'b0}));
      end else if (!b1.cpumc_r_nw_out) begin
         if (q1.size() == 0) check_eq("u1_extra_write", 32'(b1.cpumc_a_out), 32'hFFFF_FFFF);
         else begin
            e1 = q1.pop_front();
            check_eq("u1_src_addr", 32'(pa1), 32'(e1.addr));
            check_eq("u1_dst_addr", 32'(b1.cpumc_a_out), 32'(DST));
            check_eq("u1_data", 32'(b1.cpumc_d_out), 32'(e1.data));
            check_eq("u1_done", 32'(b1.done_out), 32'(e1.last));
         end
      end
      pa1 = b1.cpumc_a_out;
   end

   always @(negedge clk) begin
      if (b2.active_out) act2++;
      if (b2.done_out) done2++;
      if (!b2.active_out) begin
         check_eq("u2_idle_bus", 32'({b2.cpumc_a_out, b2.cpumc_d_out, b2.cpumc_r_nw_out, b2.done_out}),
                  32'({16'h0000, 8'h00, 1'b1, 1'b0}));
      end else if (!b2.cpumc_r_nw_out) begin
         if (q2.size() == 0) check_eq("u2_extra_write", 32'(b2.cpumc_a_out), 32'hFFFF_FFFF);
         else begin
            e2 = q2.pop_front();
            check_eq("u2_src_addr", 32'(pa2), 32'(e2.addr));
            check_eq("u2_dst_addr", 32'(b2.cpumc_a_out), 32'(DST));
            check_eq("u2_data", 32'(b2.cpumc_d_out), 32'(e2.data));
            check_eq("u2_done", 32'(b2.done_out), 32'(e2.last));
         end
      end
      pa2 = b2.cpumc_a_out;
   end

   task automatic push_exp(input int which, input logic [7:0] page);
      int          n;
      exp_t        e;
      logic [15:0] ad;
      n = (which == 0) ? 256 : ((which == 1) ? 4 : 4096);
      for (int i = 0; i < n; i++) begin
         ad     = {page, 8'h00} + 16'(i);
         e.addr = ad;
         e.data = mem(ad);
         e.last = (i == n - 1);
         case (which)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endtask

   task automatic set_cpu(input int which, input logic [15:0] a, input logic [7:0] din, input logic r_nw);
      case (which)
         0: begin b0.cpumc_a_in = a; b0.cpumc_din_in = din; b0.cpu_r_nw_in = r_nw; end
         1: begin b1.cpumc_a_in = a; b1.cpumc_din_in = din; b1.cpu_r_nw_in = r_nw; end
         default: begin b2.cpumc_a_in = a; b2.cpumc_din_in = din; b2.cpu_r_nw_in = r_nw; end
      endcase
   endtask

   task automatic trig(input int which, input logic [7:0] page, input bit push);
      @(negedge clk);
      set_cpu(which, TRIG, page, 1'b0);
      if (push) push_exp(which, page);
      @(negedge clk);
      set_cpu(which, 16'h0000, 8'h00, 1'b1);
   endtask

   function automatic logic get_active(input int which);
      case (which)
         0:       return b0.active_out;
         1:       return b1.active_out;
         default: return b2.active_out;
      endcase
   endfunction

   task automatic wait_inactive(input int which, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk); #1;
         if (get_active(which)) seen = 1'b1;
         else if (seen) return;
      end
      check_eq("wait_inactive_timeout", 32'(which), 32'hFFFF_FFFF);
   endtask

   initial begin
      bit found;
      rst = 1'b1;
      for (int w = 0; w < 3; w++) set_cpu(w, 16'h0000, 8'h00, 1'b1);
      b0.pause_in = 1'b0; b1.pause_in = 1'b0; b2.pause_in = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_active", 32'(b0.active_out), 0);
      check_eq("rst_a", 32'(b0.cpumc_a_out), 0);
      check_eq("rst_d", 32'(b0.cpumc_d_out), 0);
      check_eq("rst_r_nw", 32'(b0.cpumc_r_nw_out), 1);
      check_eq("rst_done", 32'(b0.done_out), 0);
      check_eq("rst_cnt", 32'(b0.cnt_out), 0);
      rst = 1'b0;

      // Full default transfer from page 02.
      act0 = 0; done0 = 0;
      trig(0, 8'h02, 1'b1);
      wait_inactive(0, 2000);
      check_eq("t1_active_cycles", act0, 769);
      check_eq("t1_done_pulses", done0, 1);
      check_eq("t1_cnt", 32'(b0.cnt_out), 256);
      check_eq("t1_queue_empty", q0.size(), 0);
      repeat (2) @(negedge clk);

      // Pause held for 10 cycles starting in byte 5's write.
      act0 = 0; wr0 = 0;
      trig(0, 8'h02, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk); #1;
         if (b0.active_out && !b0.cpumc_r_nw_out && wr0 == 5) found = 1'b1;
      end
      check_eq("t3_found_write5", 32'(found), 1);
      b0.pause_in = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check_eq("t3_pause_bus", 32'({b0.active_out, b0.cpumc_a_out, b0.cpumc_r_nw_out}),
               32'({1'b1, 16'h0000, 1'b1}));
      repeat (5) @(negedge clk);
      b0.pause_in = 1'b0;
      @(negedge clk); #1;
      check_eq("t3_resume_read", 32'({b0.active_out, b0.cpumc_a_out, b0.cpumc_r_nw_out}),
               32'({1'b1, 16'h0205, 1'b1}));
      wait_inactive(0, 2000);
      check_eq("t3_active_cycles", act0, 779);
      check_eq("t3_cnt", 32'(b0.cnt_out), 256);
      check_eq("t3_queue_empty", q0.size(), 0);
      repeat (2) @(negedge clk);

      // Retrigger mid-transfer is ignored; a held trigger write keeps COOLDOWN.
      act0 = 0; done0 = 0;
      trig(0, 8'h02, 1'b1);
      repeat (30) @(negedge clk);
      trig(0, 8'h07, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk); #1;
         if (b0.done_out) found = 1'b1;
      end
      check_eq("t4_done_seen", 32'(found), 1);
      set_cpu(0, TRIG, 8'h07, 1'b0);
      act0 = 0;
      repeat (20) @(negedge clk);
      #1;
      check_eq("t4_cooldown_hold", act0, 0);
      check_eq("t4_cnt_hold", 32'(b0.cnt_out), 256);
      set_cpu(0, 16'h0000, 8'h00, 1'b1);
      repeat (5) @(negedge clk);
      #1;
      check_eq("t4_no_retrigger", act0, 0);
      check_eq("t4_done_pulses", done0, 1);
      check_eq("t4_queue_empty", q0.size(), 0);

      // Reset during byte 100's read, then a clean restart.
      trig(0, 8'h02, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk); #1;
         if (b0.active_out && b0.cpumc_r_nw_out && b0.cpumc_a_out == 16'h0263) found = 1'b1;
      end
      check_eq("t5_found_read100", 32'(found), 1);
      rst = 1'b1;
      @(negedge clk); #1;
      check_eq("t5_rst_state", 32'({b0.active_out, b0.cpumc_r_nw_out, b0.cpumc_a_out, b0.done_out}),
               32'({1'b0, 1'b1, 16'h0000, 1'b0}));
      check_eq("t5_rst_cnt", 32'(b0.cnt_out), 0);
      rst = 1'b0;
      q0.delete();
      repeat (5) @(negedge clk);
      #1;
      check_eq("t5_stays_idle", 32'(b0.active_out), 0);
      act0 = 0; done0 = 0;
      trig(0, 8'h03, 1'b1);
      wait_inactive(0, 2000);
      check_eq("t5_active_cycles", act0, 769);
      check_eq("t5_cnt", 32'(b0.cnt_out), 256);
      check_eq("t5_done_pulses", done0, 1);
      check_eq("t5_queue_empty", q0.size(), 0);

      // Short transfer with longer read latency and no alignment stall.
      act1 = 0; done1 = 0;
      trig(1, 8'hFF, 1'b1);
      wait_inactive(1, 200);
      check_eq("t2_active_cycles", act1, 16);
      check_eq("t2_cnt", 32'(b1.cnt_out), 4);
      check_eq("t2_done_pulses", done1, 1);
      check_eq("t2_queue_empty", q1.size(), 0);

      // Long transfer from page FF wraps the source address through 0000.
      act2 = 0; done2 = 0;
      trig(2, 8'hFF, 1'b1);
      wait_inactive(2, 20000);
      check_eq("t2w_active_cycles", act2, 16384);
      check_eq("t2w_cnt", 32'(b2.cnt_out), 4096);
      check_eq("t2w_done_pulses", done2, 1);
      check_eq("t2w_queue_empty", q2.size(), 0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
